// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM encoding, scan default and 7-segment lookup for the BCD display driver
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int SCAN_DIV_DEFAULT = 4;
  localparam logic [15:0][6:0] SEG_LUT = {
    {6{7'h00}},
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-high {g,f,e,d,c,b,a} segments with blanking
module seg7_decode
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);
  assign seg = blank ? 7'h00 : SEG_LUT[digit];
endmodule

// File: rtl/bcd_display_driver.sv
// bcd_display_driver: sequential double-dabble binary-to-BCD plus free-running 3-digit scan
module bcd_display_driver
  import bcd_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  value,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic [2:0]  an,
  output logic [6:0]  seg
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  state_t state, state_n;
  logic [7:0] op;
  logic [11:0] scr, adj;
  logic [2:0] cnt;
  logic [CW-1:0] div;
  logic [1:0] idx;
  logic [3:0] digit;
  logic blank, wrap;
  logic [6:0] seg_d;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    if (state == IDLE && start) state_n = SHIFT;
    else if (state == SHIFT && cnt == 3'd7) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
  end
  for (genvar i = 0; i < 3; i++) begin : g_adj
    assign adj[4*i+:4] = scr[4*i+:4] >= 4'd5 ? scr[4*i+:4] + 4'd3 : scr[4*i+:4];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
      bcd   <= 12'h000;
      op    <= 8'h00;
      scr   <= 12'h000;
      cnt   <= 3'd0;
    end else begin
      state <= state_n;
      done  <= state == DONE;
      if (state == IDLE && start) begin
        op  <= value;
        scr <= 12'h000;
        cnt <= 3'd0;
      end else if (state == SHIFT) begin
        {scr, op} <= {adj, op} << 1;
        cnt <= cnt + 3'd1;
      end
      if (state == DONE) bcd <= scr;
    end
  end
  // scan runs from the committed result only, so partial conversions never reach the display
  assign wrap  = div == CW'(SCAN_DIV - 1);
  assign digit = idx == 2'd2 ? bcd[11:8] : idx == 2'd1 ? bcd[7:4] : bcd[3:0];
  assign blank = idx == 2'd2 ? bcd[11:8] == 4'd0 : idx == 2'd1 ? bcd[11:4] == 8'd0 : 1'b0;
  seg7_decode u_dec (.digit(digit), .blank(blank), .seg(seg_d));
  always_ff @(posedge clock) begin
    if (reset) begin
      div <= '0;
      idx <= 2'd0;
      an  <= 3'b001;
      seg <= 7'h3F;
    end else begin
      div <= wrap ? '0 : div + CW'(1);
      if (wrap) idx <= idx == 2'd2 ? 2'd0 : idx + 2'd1;
      an  <= 3'b001 << idx;
      seg <= seg_d;
    end
  end
endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver: randomized self-checking bench against an arithmetic BCD/display model
module tb_bcd_display_driver;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] value = 8'h00;
  logic busy, done, busy1, done1;
  logic [11:0] bcd, bcd1;
  logic [2:0] an, an1;
  logic [6:0] seg, seg1;
  int total = 0, bad = 0;

  bcd_display_driver #(.SCAN_DIV(4)) dut (
    .clock(clock), .reset(reset), .start(start), .value(value),
    .busy(busy), .done(done), .bcd(bcd), .an(an), .seg(seg));
  bcd_display_driver #(.SCAN_DIV(1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .value(value),
    .busy(busy1), .done(done1), .bcd(bcd1), .an(an1), .seg(seg1));

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input logic [2:0] a);
    int h, t, o;
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    if (a == 3'b100) return h == 0 ? 7'h00 : pat(h);
    if (a == 3'b010) return (h == 0 && t == 0) ? 7'h00 : pat(t);
    return pat(o);
  endfunction

  task automatic check_reset_outputs(input string name);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000 || an !== 3'b001 || seg !== 7'h3F) begin
      bad++;
      $display("FAIL %s: busy=%b done=%b bcd=%h an=%b seg=%h, want 0 0 000 001 3f", name, busy, done, bcd, an, seg);
    end
  endtask

  task automatic run_conv(input logic [7:0] v, output int busy_n, output int done_at, output int done_n);
    start = 1'b1; value = v;
    tick;
    start = 1'b0; value = 8'($urandom);
    busy_n = 0; done_at = -1; done_n = 0;
    for (int i = 0; i <= 12; i++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      if (i < 12) tick;
    end
  endtask

  task automatic check_display(input int v, input string name);
    logic [2:0] seen;
    seen = 3'b000;
    tick; tick;
    for (int i = 0; i < 15; i++) begin
      total++;
      if (an != 3'b001 && an != 3'b010 && an != 3'b100) begin
        bad++;
        $display("FAIL %s an: got %b, want one-hot digit", name, an);
      end else if (seg !== exp_seg(v, an)) begin
        bad++;
        $display("FAIL %s seg an=%b: got %h, want %h", name, an, seg, exp_seg(v, an));
      end
      seen |= an;
      tick;
    end
    total++;
    if (seen !== 3'b111) begin
      bad++;
      $display("FAIL %s digits seen: got %b, want 111", name, seen);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; value = 8'hAB;
    tick; tick;
    check_reset_outputs("reset");
    reset = 1'b0; start = 1'b0;
  endtask

  task automatic test_ff;
    int bn, da, dn;
    run_conv(8'hFF, bn, da, dn);
    total++;
    if (bn != 9) begin bad++; $display("FAIL ff busy cycles: got %0d, want 9", bn); end
    total++;
    if (da != 9 || dn != 1) begin bad++; $display("FAIL ff done: at %0d count %0d, want at 9 count 1", da, dn); end
    total++;
    if (bcd !== to_bcd(255)) begin bad++; $display("FAIL ff bcd: got %h, want %h", bcd, to_bcd(255)); end
    check_display(255, "ff display");
  endtask

  task automatic test_small;
    int bn, da, dn;
    run_conv(8'h07, bn, da, dn);
    total++;
    if (bcd !== 12'h007) begin bad++; $display("FAIL seven bcd: got %h, want 007", bcd); end
    check_display(7, "seven display");
  endtask

  task automatic test_random;
    int bn, da, dn, v;
    for (int n = 0; n < 24; n++) begin
      v = n == 0 ? 0 : n == 1 ? 100 : n == 2 ? 99 : n == 3 ? 10 : int'($urandom_range(255));
      run_conv(8'(v), bn, da, dn);
      total++;
      if (bcd !== to_bcd(v) || da != 9 || dn != 1 || bn != 9) begin
        bad++;
        $display("FAIL random v=%0d: bcd=%h done_at=%0d dn=%0d busy=%0d, want %h 9 1 9", v, bcd, da, dn, bn, to_bcd(v));
      end
      if (n % 6 == 0) check_display(v, "random display");
    end
  endtask

  task automatic test_back_to_back;
    int q[$];
    int dones, want;
    logic [7:0] ctr;
    ctr = 8'($urandom);
    dones = 0;
    for (int e = 0; e < 300; e++) begin
      start = 1'b1; value = ctr;
      tick;
      if (e % 10 == 0) q.push_back(int'(ctr));
      ctr = ctr + 8'd1;
      if (done) begin
        dones++;
        want = q.size() > 0 ? q.pop_front() : -1;
        total++;
        if (e % 10 != 9 || want < 0 || bcd !== to_bcd(want)) begin
          bad++;
          $display("FAIL b2b edge %0d: bcd=%h, want %h at period phase 9", e, bcd, to_bcd(want));
        end
      end
    end
    start = 1'b0;
    tick;
    total++;
    if (dones != 30) begin bad++; $display("FAIL b2b done count: got %0d, want 30", dones); end
    for (int i = 0; i < 10; i++) tick;
  endtask

  task automatic test_ignore;
    int a, b, da;
    a = int'($urandom_range(255));
    b = (a + 1 + int'($urandom_range(200))) % 256;
    start = 1'b1; value = 8'(a);
    tick;
    start = 1'b0; value = 8'(b);
    tick; tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    da = -1;
    for (int i = 3; i < 16 && da < 0; i++) begin
      if (done) da = i;
      else tick;
    end
    total++;
    if (da != 9 || bcd !== to_bcd(a)) begin
      bad++;
      $display("FAIL ignore: done_at=%0d bcd=%h, want 9 %h", da, bcd, to_bcd(a));
    end
    tick;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL ignore recapture: busy=%b, want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int dn;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    start = 1'b1; value = 8'hC8;
    tick;
    start = 1'b0;
    for (int i = 1; i < 5; i++) tick;
    reset = 1'b1;
    tick;
    check_reset_outputs("reset mid");
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (done || busy) dn++;
    end
    total++;
    if (dn != 0 || bcd !== 12'h000) begin
      bad++;
      $display("FAIL reset mid aftermath: done/busy cycles=%0d bcd=%h, want 0 000", dn, bcd);
    end
  endtask

  task automatic test_scan;
    logic [2:0] prev [2];
    int run [2];
    int div [2];
    bit changed [2];
    logic [2:0] a;
    div[0] = 4; div[1] = 1;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin prev[k] = 3'b001; run[k] = 1; changed[k] = 0; end
    for (int i = 0; i < 40; i++) begin
      tick;
      for (int k = 0; k < 2; k++) begin
        a = k == 0 ? an : an1;
        if (a != prev[k]) begin
          total++;
          if (a !== {prev[k][1:0], prev[k][2]} || (changed[k] && run[k] != div[k])) begin
            bad++;
            $display("FAIL scan div=%0d: an %b after %b held %0d, want %b held %0d",
                     div[k], a, prev[k], run[k], {prev[k][1:0], prev[k][2]}, div[k]);
          end
          changed[k] = 1; run[k] = 1; prev[k] = a;
        end else run[k]++;
      end
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if (!changed[k] || run[k] > div[k]) begin
        bad++;
        $display("FAIL scan div=%0d stalled: run %0d, want <= %0d", div[k], run[k], div[k]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_ff;
    test_small;
    test_random;
    test_back_to_back;
    test_ignore;
    test_reset_mid;
    test_scan;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
